qmem_addr_decoder: RTL and testbench

Address-decoding QMEM fabric node, the parametrised successor to the one-hot-select decoder. It sits between one QMEM master (CPU instruction or data port) and up to 16 QMEM slaves and decodes the slave from the address using per-slave base/mask pairs. Unmapped accesses are terminated with a local error, and stalled slaves are aborted by a per-transfer watchdog. The address of the last faulting access is captured for software.

---
 rtl/qmem_addr_decoder.sv | 146 ++++++++++++++
 tb/tb_qmem_addr_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/qmem_addr_decoder.sv
// QMEM fabric node: one master to SN slaves, address decoded by per-slave base/mask.
// Unmapped accesses and stalled slaves are answered locally with an error.
module qmem_addr_decoder #(
  parameter int                  QAW      = 32,
  parameter int                  QDW      = 32,
  parameter int                  QSW      = QDW/8,
  parameter int                  SN       = 2,
  parameter logic [SN*QAW-1:0]   SLV_BASE = '0,
  parameter logic [SN*QAW-1:0]   SLV_MASK = '0,
  parameter int                  TMO_CYC  = 255,
  parameter int                  TMO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              qm_cs,
  input  logic              qm_we,
  input  logic [QSW-1:0]    qm_sel,
  input  logic [QAW-1:0]    qm_adr,
  input  logic [QDW-1:0]    qm_dat_w,
  output logic [QDW-1:0]    qm_dat_r,
  output logic              qm_ack,
  output logic              qm_err,
  output logic [SN-1:0]     qs_cs,
  output logic [SN-1:0]     qs_we,
  output logic [SN*QSW-1:0] qs_sel,
  output logic [SN*QAW-1:0] qs_adr,
  output logic [SN*QDW-1:0] qs_dat_w,
  input  logic [SN*QDW-1:0] qs_dat_r,
  input  logic [SN-1:0]     qs_ack,
  input  logic [SN-1:0]     qs_err,
  output logic              dec_err,
  output logic              tmo_err,
  output logic [QAW-1:0]    err_adr
);

  localparam int IW = (SN > 1) ? $clog2(SN) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);
  localparam logic TMO_ON = (TMO_CYC != 0);

  logic [SN-1:0]    hit;
  logic             any_hit;
  logic [IW-1:0]    sel_idx;
  logic             slv_ack;
  logic             slv_err;
  logic [QDW-1:0]   slv_dat [SN];

  logic             nohit_reg, nohit_next;
  logic             tmo_reg, tmo_next;
  logic [TMO_W-1:0] cnt_reg, cnt_next;
  logic             rd_zero_reg, rd_zero_next;
  logic [IW-1:0]    rd_idx_reg, rd_idx_next;
  logic [QAW-1:0]   err_adr_reg, err_adr_next;

  logic             cnt_inc;
  logic             cnt_clr;
  logic             tmo_fire;
  logic             rd_done;

  genvar gi;
  generate
    for (gi = 0; gi < SN; gi++) begin : g_slv
      assign hit[gi] = ((qm_adr & SLV_MASK[QAW*gi +: QAW]) == SLV_BASE[QAW*gi +: QAW]);
      assign qs_cs[gi]                   = qm_cs & any_hit & ~tmo_reg & (sel_idx == IW'(gi));
      assign qs_we[gi]                   = qm_we;
      assign qs_sel[QSW*gi +: QSW]       = qm_sel;
      assign qs_adr[QAW*gi +: QAW]       = qm_adr;
      assign qs_dat_w[QDW*gi +: QDW]     = qm_dat_w;
      assign slv_dat[gi]                 = qs_dat_r[QDW*gi +: QDW];
    end
  endgenerate

  assign any_hit = |hit;

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    sel_idx = '0;
    for (int i = SN - 1; i >= 0; i--) begin
      if (hit[i]) sel_idx = IW'(i);
    end
  end

  always_comb begin
    slv_ack  = 1'b0;
    slv_err  = 1'b0;
    qm_dat_r = '0;
    for (int i = 0; i < SN; i++) begin
      if (sel_idx == IW'(i)) begin
        slv_ack = qs_ack[i];
        slv_err = qs_err[i];
      end
      if (!rd_zero_reg && rd_idx_reg == IW'(i)) qm_dat_r = slv_dat[i];
    end
  end

  assign qm_ack  = any_hit & slv_ack & ~tmo_reg;
  assign qm_err  = (any_hit & slv_err & ~tmo_reg) | nohit_reg | tmo_reg;
  assign dec_err = nohit_reg;
  assign tmo_err = tmo_reg;
  assign err_adr = err_adr_reg;

  assign cnt_inc  = qm_cs & any_hit & ~qm_ack & ~qm_err;
  assign cnt_clr  = ~qm_cs | qm_ack | qm_err | tmo_reg;
  assign tmo_fire = TMO_ON & cnt_inc & (cnt_reg == TMO_LAST);
  assign rd_done  = qm_cs & ~qm_we;

  always_comb begin
    nohit_next   = qm_cs & ~any_hit & ~nohit_reg;
    tmo_next     = tmo_fire;
    cnt_next     = cnt_reg;
    rd_zero_next = rd_zero_reg;
    rd_idx_next  = rd_idx_reg;
    err_adr_next = err_adr_reg;

    if (cnt_clr || tmo_fire) cnt_next = '0;
    else if (cnt_inc)        cnt_next = cnt_reg + 1'b1;

    // Locally terminated reads return zero rather than stale slave data.
    if (rd_done && (nohit_reg || tmo_reg)) begin
      rd_zero_next = 1'b1;
    end else if (rd_done && any_hit && (slv_ack || slv_err)) begin
      rd_zero_next = 1'b0;
      rd_idx_next  = sel_idx;
    end

    if (nohit_reg || tmo_reg) err_adr_next = qm_adr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nohit_reg   <= 1'b0;
      tmo_reg     <= 1'b0;
      cnt_reg     <= '0;
      rd_zero_reg <= 1'b1;
      rd_idx_reg  <= '0;
      err_adr_reg <= '0;
    end else begin
      nohit_reg   <= nohit_next;
      tmo_reg     <= tmo_next;
      cnt_reg     <= cnt_next;
      rd_zero_reg <= rd_zero_next;
      rd_idx_reg  <= rd_idx_next;
      err_adr_reg <= err_adr_next;
    end
  end

endmodule

// File: tb/tb_qmem_addr_decoder.sv
// Directed bench for qmem_addr_decoder: four slaves, slave 3 overlaps slave 1, watchdog of 4 cycles.
module tb_qmem_addr_decoder;

  localparam int QAW = 32;
  localparam int QDW = 32;
  localparam int QSW = 4;
  localparam int SN  = 4;
  localparam logic [SN*QAW-1:0] BASE = {32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [SN*QAW-1:0] MASK = {32'hFF00_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
  localparam logic [31:0] S0 = 32'h1111_0000;
  localparam logic [31:0] S1 = 32'h2222_0001;
  localparam logic [31:0] S2 = 32'hDEAD_BEEF;
  localparam logic [31:0] S3 = 32'h3333_0003;

  logic              clk = 1'b0;
  logic              rst;
  logic              qm_cs, qm_we;
  logic [QSW-1:0]    qm_sel;
  logic [QAW-1:0]    qm_adr;
  logic [QDW-1:0]    qm_dat_w;
  logic [QDW-1:0]    qm_dat_r;
  logic              qm_ack, qm_err;
  logic [SN-1:0]     qs_cs, qs_we;
  logic [SN*QSW-1:0] qs_sel;
  logic [SN*QAW-1:0] qs_adr;
  logic [SN*QDW-1:0] qs_dat_w;
  logic [SN*QDW-1:0] qs_dat_r;
  logic [SN-1:0]     qs_ack, qs_err;
  logic              dec_err, tmo_err;
  logic [QAW-1:0]    err_adr;

  int total = 0;
  int bad   = 0;

  qmem_addr_decoder #(
    .QAW(QAW), .QDW(QDW), .QSW(QSW), .SN(SN),
    .SLV_BASE(BASE), .SLV_MASK(MASK), .TMO_CYC(4), .TMO_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .qm_cs(qm_cs), .qm_we(qm_we), .qm_sel(qm_sel), .qm_adr(qm_adr),
    .qm_dat_w(qm_dat_w), .qm_dat_r(qm_dat_r), .qm_ack(qm_ack), .qm_err(qm_err),
    .qs_cs(qs_cs), .qs_we(qs_we), .qs_sel(qs_sel), .qs_adr(qs_adr),
    .qs_dat_w(qs_dat_w), .qs_dat_r(qs_dat_r), .qs_ack(qs_ack), .qs_err(qs_err),
    .dec_err(dec_err), .tmo_err(tmo_err), .err_adr(err_adr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [3:0]  exp_cs;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cs, input logic we, input logic [31:0] adr,
                       input logic [3:0] ack, input logic [3:0] err);
    qm_cs  = cs;
    qm_we  = we;
    qm_adr = adr;
    qs_ack = ack;
    qs_err = err;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h1000_0004, 4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h2000_0008, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h2000_0008, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, S2};
    vecs[3]  = '{1'b0, 32'h1000_0000, 4'b1010, 4'b0000, 4'b0010, 1'b1, 1'b0, S1};
    vecs[4]  = '{1'b0, 32'h1000_0000, 4'b1000, 4'b0000, 4'b0010, 1'b0, 1'b0, S1};
    vecs[5]  = '{1'b0, 32'h0000_0010, 4'b0000, 4'b0001, 4'b0001, 1'b0, 1'b1, S0};
    vecs[6]  = '{1'b1, 32'h2000_0000, 4'b0100, 4'b0010, 4'b0100, 1'b1, 1'b0, S0};
    vecs[7]  = '{1'b0, 32'h1F00_0000, 4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, S1};
    vecs[8]  = '{1'b0, 32'h0FFF_FFFC, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, S0};
    vecs[9]  = '{1'b0, 32'h2000_0000, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, S2};
    vecs[10] = '{1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, S2};
    vecs[11] = '{1'b0, 32'h0000_0000, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, S0};

    qs_dat_r = {S3, S2, S1, S0};
    qm_sel   = 4'hF;
    qm_dat_w = 32'hCAFE_0123;
    drive(1'b0, 1'b0, 32'h0, 4'b0, 4'b0);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_dat_r", qm_dat_r, 0);
    chk("rst_ack", qm_ack, 0);
    chk("rst_err", qm_err, 0);
    chk("rst_dec_err", dec_err, 0);
    chk("rst_tmo_err", tmo_err, 0);
    chk("rst_qs_cs", qs_cs, 0);
    chk("rst_err_adr", err_adr, 0);
    $display("reset: dat_r=%h cs=%b", qm_dat_r, qs_cs);
    tick();

    for (int v = 0; v < 12; v++) begin
      drive(1'b1, vecs[v].we, vecs[v].adr, vecs[v].ack, vecs[v].err);
      @(negedge clk);
      chk($sformatf("v%0d_qs_cs", v), qs_cs, vecs[v].exp_cs);
      chk($sformatf("v%0d_ack", v), qm_ack, vecs[v].exp_ack);
      chk($sformatf("v%0d_err", v), qm_err, vecs[v].exp_err);
      chk($sformatf("v%0d_qs_adr", v), qs_adr, {4{vecs[v].adr}});
      chk($sformatf("v%0d_qs_we", v), qs_we, {4{vecs[v].we}});
      tick();
      chk($sformatf("v%0d_dat_r", v), qm_dat_r, vecs[v].exp_dat);
      $display("vec %0d: we=%b adr=%h cs=%b ack=%b err=%b dat_r=%h",
               v, vecs[v].we, vecs[v].adr, qs_cs, qm_ack, qm_err, qm_dat_r);
    end
    drive(1'b0, 1'b0, 32'h0, 4'b0, 4'b0);
    tick();

    // Unmapped read: error one cycle after cs, address captured, data zeroed.
    drive(1'b1, 1'b0, 32'h8000_0000, 4'b0, 4'b0);
    @(negedge clk);
    chk("unm_c0_err", qm_err, 0);
    chk("unm_c0_cs", qs_cs, 0);
    tick();
    @(negedge clk);
    chk("unm_c1_err", qm_err, 1);
    chk("unm_c1_dec", dec_err, 1);
    chk("unm_c1_cs", qs_cs, 0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 4'b0, 4'b0);
    @(negedge clk);
    chk("unm_err_adr", err_adr, 32'h8000_0000);
    chk("unm_dat_r", qm_dat_r, 0);
    chk("unm_dec_end", dec_err, 0);
    $display("unmapped read: err_adr=%h dat_r=%h", err_adr, qm_dat_r);
    tick();

    // Two back-to-back unmapped reads: errors in cycles 1 and 3.
    drive(1'b1, 1'b0, 32'h9000_0000, 4'b0, 4'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_unm_c%0d_err", c), qm_err, (c % 2 == 1));
      chk($sformatf("b2b_unm_c%0d_dec", c), dec_err, (c % 2 == 1));
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 4'b0, 4'b0);
    $display("back-to-back unmapped reads done");
    tick();

    // Prime read data with slave 2 so the watchdog zeroing is visible.
    drive(1'b1, 1'b0, 32'h2000_0000, 4'b0100, 4'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 4'b0, 4'b0);
    @(negedge clk);
    chk("prime_dat_r", qm_dat_r, S2);
    tick();

    // Watchdog: slave 0 silent for 4 cycles, late ack in the timeout cycle is ignored.
    drive(1'b1, 1'b0, 32'h0000_0040, 4'b0, 4'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("wd_c%0d_cs", c), qs_cs, 4'b0001);
      chk($sformatf("wd_c%0d_err", c), qm_err, 0);
      tick();
    end
    qs_ack = 4'b0001;
    @(negedge clk);
    chk("wd_c4_err", qm_err, 1);
    chk("wd_c4_tmo", tmo_err, 1);
    chk("wd_c4_ack", qm_ack, 0);
    chk("wd_c4_cs", qs_cs, 0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 4'b0, 4'b0);
    @(negedge clk);
    chk("wd_tmo_end", tmo_err, 0);
    chk("wd_err_adr", err_adr, 32'h0000_0040);
    chk("wd_dat_r", qm_dat_r, 0);
    $display("watchdog: err_adr=%h dat_r=%h", err_adr, qm_dat_r);
    tick();

    // Reset in the middle of a watchdog count (cnt=3).
    drive(1'b1, 1'b0, 32'h1000_0000, 4'b0010, 4'b0);
    tick();
    drive(1'b1, 1'b0, 32'h1000_0000, 4'b0000, 4'b0);
    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstwd_err", qm_err, 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rstwd_c%0d_err", c), qm_err, 0);
      chk($sformatf("rstwd_c%0d_tmo", c), tmo_err, 0);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 4'b0, 4'b0);
    @(negedge clk);
    chk("post_rst_dat_r", qm_dat_r, 0);
    chk("post_rst_ack", qm_ack, 0);
    chk("post_rst_err", qm_err, 0);
    chk("post_rst_cs", qs_cs, 0);
    chk("post_rst_dec", dec_err, 0);
    chk("post_rst_err_adr", err_adr, 0);
    $display("reset mid-watchdog: err=%b tmo=%b dat_r=%h", qm_err, tmo_err, qm_dat_r);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
